// File: rtl/fetch_byte_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_byte_queue
//  Purpose  : Instruction byte queue between instruction memory and the
//             decoder. It aligns the first word after a redirect and shows
//             the decoder a 16-byte window.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_byte_queue #(
    parameter int QUEUE_BYTES  = 32,
    parameter int LOAD_LATENCY = 1,
    parameter int ADDR_W       = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [63:0]       mem_data_i,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_byte_pc_i,
    input  logic              flush_i,
    input  logic [4:0]        consume_n_i,
    output logic [127:0]      inst_bytes_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic [4:0]        inst_count_o,
    output logic              stall_pc_o,
    output logic              ovf_err_o
);

    localparam int CW         = $clog2(QUEUE_BYTES + 1);
    localparam int QW         = QUEUE_BYTES * 8;
    localparam int STALL_ROOM = 8 * (LOAD_LATENCY + 1);

    typedef enum logic [0:0] {
        S_REDIRECT = 1'b0,
        S_RUN      = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [ADDR_W-1:0] fill_pc_q, fill_pc_d;
    logic [QW-1:0]     queue_q, queue_d;
    logic              ovf_q, ovf_d;

    logic [4:0]        win_count;
    logic [4:0]        cons_c;
    logic [QW-1:0]     shifted;
    logic [CW:0]       base;
    logic [CW:0]       total;
    logic [3:0]        app_n;
    logic [63:0]       word;
    logic              accept;

    assign win_count = (count_q > CW'(16)) ? 5'd16 : count_q[4:0];

    always_comb begin
        cons_c    = (consume_n_i > win_count) ? win_count : consume_n_i;
        shifted   = queue_q >> {cons_c, 3'b000};
        base      = {1'b0, count_q} - (CW+1)'(cons_c);
        state_d   = state_q;
        fill_pc_d = fill_pc_q;
        head_pc_d = head_pc_q + ADDR_W'(cons_c);
        ovf_d     = ovf_q;
        accept    = 1'b0;
        app_n     = 4'd0;
        word      = mem_data_i;

        case (state_q)
            S_REDIRECT: begin
                // Leading bytes below the entry offset belong to an earlier instruction.
                if (mem_valid_i) begin
                    accept    = 1'b1;
                    word      = mem_data_i >> {mem_byte_pc_i[2:0], 3'b000};
                    app_n     = 4'd8 - {1'b0, mem_byte_pc_i[2:0]};
                    head_pc_d = mem_byte_pc_i;
                    fill_pc_d = {mem_byte_pc_i[ADDR_W-1:3], 3'b000} + ADDR_W'(8);
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (mem_valid_i && (mem_byte_pc_i == fill_pc_q)) begin
                    accept    = 1'b1;
                    app_n     = 4'd8;
                    fill_pc_d = fill_pc_q + ADDR_W'(8);
                end
            end
            default: ;
        endcase

        total   = base + (CW+1)'(app_n);
        // Bytes shifted past the top of the vector are the overflow excess.
        queue_d = shifted | (accept ? (QW'(word) << {base, 3'b000}) : '0);
        if (total > (CW+1)'(QUEUE_BYTES)) begin
            count_d = CW'(QUEUE_BYTES);
            ovf_d   = 1'b1;
        end else begin
            count_d = total[CW-1:0];
        end

        if (flush_i) begin
            state_d   = S_REDIRECT;
            count_d   = '0;
            queue_d   = '0;
            head_pc_d = head_pc_q;
            fill_pc_d = fill_pc_q;
            ovf_d     = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_REDIRECT;
            count_q   <= '0;
            head_pc_q <= '0;
            fill_pc_q <= '0;
            queue_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            fill_pc_q <= fill_pc_d;
            queue_q   <= queue_d;
            ovf_q     <= ovf_d;
        end
    end

    assign inst_bytes_o = queue_q[127:0];
    assign inst_pc_o    = head_pc_q;
    assign inst_count_o = win_count;
    assign ovf_err_o    = ovf_q;
    assign stall_pc_o   = (state_q == S_RUN) &&
                          ((32'(count_q) + 32'(STALL_ROOM)) > 32'(QUEUE_BYTES));

endmodule
`default_nettype wire

// File: doc/fetch_byte_queue.md
# fetch_byte_queue

Front-end instruction byte queue between instruction memory and the x86-64 decoder. It takes the 64-bit words fetched at `pc_to_mem` and tagged with the write-back stage's `pc_to_fet` byte PC. It strips the misaligned leading bytes after a redirect and presents a 16-byte window, starting at the current instruction's byte PC, to the decoder. It also produces `stall_pc` for the write-back stage's RIP/pc_queue, and discards stale, duplicate and flushed words.

## Interface
- `QUEUE_BYTES`, default 32: queue capacity in bytes; must be a multiple of 8 and ≥ 24.
- `LOAD_LATENCY`, default 1: instruction memory read latency; sizes the stall headroom.
- `clk` in 1: clock.
- `rstn` in 1: reset `rstn`, synchronous, active-low; clock `clk`.
- `mem_data` in `DATA_W`(64): fetched word; byte k is `[8k+7:8k]`.
- `mem_valid` in 1: `mem_data` valid this cycle.
- `mem_byte_pc` in `ADDR_W`: byte PC tag of `mem_data`. Bits [2:0] are the entry offset after a redirect.
- `flush` in 1: branch redirect in progress; held LOAD_LATENCY cycles by upstream.
- `consume_n` in 5: bytes retired by the decoder this cycle, 0..16.
- `inst_bytes` out 128: window; byte 0 is at `inst_pc`; bytes ≥ `inst_count` read 0.
- `inst_pc` out `ADDR_W`: byte PC of window byte 0.
- `inst_count` out 5: valid window bytes, min(count,16).
- `stall_pc` out 1: queue cannot absorb further in-flight words.
- `ovf_err` out 1: sticky; an accepted word did not fit.

## Operation
- State: `count` (0..QUEUE_BYTES, $clog2(QUEUE_BYTES+1) bits), `head_pc`, `fill_pc` (8-aligned byte PC of next expected word), and FSM {REDIRECT, RUN}.
- Per cycle, evaluated in this order:
  - If `flush`: state←REDIRECT, count←0. `mem_valid` and `consume_n` are ignored.
  - Consume: c = min(`consume_n`, `inst_count`). Clamped silently. head_pc←head_pc+c, and the queue shifts down by c bytes.
  - Accept:
    - REDIRECT: the first `mem_valid` is accepted. off=`mem_byte_pc`[2:0]. Bytes off..7 are appended (8−off bytes). head_pc←`mem_byte_pc`, fill_pc←{`mem_byte_pc`[ADDR_W-1:3],3'b0}+8, state←RUN.
    - RUN: the word is accepted only if `mem_byte_pc`==fill_pc. All 8 bytes are appended at position count−c, and fill_pc←fill_pc+8. Any other tag is discarded with no state change; these are stale or duplicate words from `stall_pc` replay.
  - Overflow: if count−c+appended > QUEUE_BYTES, the excess bytes are dropped and `ovf_err`←1. The clamped count is QUEUE_BYTES, and fill_pc still advances.
- `stall_pc` = (QUEUE_BYTES − count) < 8·(LOAD_LATENCY+1). It is computed combinationally from registered count and is 0 in REDIRECT.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- Queue byte storage beyond count is zeroed on every update, so window masking is structural.

## Timing
- Reset values: count 0, head_pc 0, fill_pc 0, state REDIRECT, `inst_bytes` 0, `inst_pc` 0, `inst_count` 0, `stall_pc` 0, `ovf_err` 0.
- All window outputs are registered views of the queue.
- A word accepted at cycle t is visible at t+1.
- `consume_n` at cycle t acts on the window shown at cycle t. The shifted window appears at t+1.
- Consume and accept in the same cycle: the consume is applied first, then the append. No bypass from `mem_data` to the window.
- `flush` has priority over consume and accept. The window empties at the next edge, and `inst_count`=0 for every cycle flush is high plus one.
- The first post-flush word needs `flush`=0 in the same cycle.
- Reset mid-operation overrides everything and returns all state to reset values at the next edge.

## Test plan
- Reset and first fill:
  - Stimulus: reset, then `mem_valid`, `mem_byte_pc`=0x0, data 0x0807060504030201.
  - Required: next cycle `inst_count`=8, `inst_bytes`[63:0]=0x0807060504030201, `inst_pc`=0, `stall_pc`=0.
- Unaligned redirect:
  - Stimulus: flush 1 cycle, then word tag 0x13, data 0x8877665544332211.
  - Required: `inst_count`=5, `inst_bytes`[39:0]=0x8877665544, `inst_pc`=0x13.
  - Follow-up: a subsequent tag 0x10 word is discarded; a tag 0x18 word gives count 13.
- Consume with append:
  - Stimulus: with count 13 at `inst_pc` 0x13, `consume_n`=3 together with word 0x20.
  - Required: count 18, `inst_pc` 0x16, `stall_pc`=1 (QUEUE_BYTES 32, LOAD_LATENCY 1).
- Stall replay:
  - Stimulus: while `stall_pc`=1, re-present tags 0x18 and 0x20.
  - Required: both discarded; count unchanged; `ovf_err`=0.
- Flush priority:
  - Stimulus: `flush`=1 together with `consume_n`=4 and a valid tag-matching word.
  - Required: next cycle count 0 and state REDIRECT; `inst_pc` changes only on the next accepted word.
- Overflow and clamp:
  - Stimulus: fill to 32 by forcing words with `stall_pc` ignored; `consume_n`=16 while `inst_count`=5.
  - Required: `ovf_err` becomes 1 and stays 1; count is clamped to 32 on overflow; the over-consume retires only 5 bytes.
